hazard_scheduler: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Takes the 6-bit register IDs decoded in ID (ReadRegister1/2, WriteRegister; 0–31 GPR, 33 = HI/LO).
- Tracks them through EX/MEM/WB in internal stage records.
- Generates load-use stalls, multiply/divide busy stalls, branch flushes and EX-stage forwarding selects.
- Sits beside the ID/EX pipeline registers and steers the datapath; it holds no data values.

---
 rtl/hazard_scheduler.sv | 130 +++++++++++++
 tb/tb_hazard_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use and HI/LO busy
// stalls, branch flushes and EX-stage forwarding selects from register IDs only.
module hazard_scheduler #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [5:0] id_rr1,
  input  logic [5:0] id_rr2,
  input  logic [5:0] id_wr,
  input  logic       id_is_load,
  input  logic       id_md_start,
  input  logic       id_md_is_div,
  input  logic       ex_branch_taken,
  output logic       stall,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       md_busy
);

  localparam logic [5:0] HILO_ID = 6'd33;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_e;

  typedef struct packed {
    logic       v;
    logic [5:0] rr1;
    logic [5:0] rr2;
    logic [5:0] wr;
    logic       ld;
  } ex_rec_t;

  ex_rec_t          ex_q, ex_d;
  logic             mem_v_q, mem_v_d;
  logic [5:0]       mem_wr_q, mem_wr_d;
  logic             mem_ld_q, mem_ld_d;
  logic             wb_v_q, wb_v_d;
  logic [5:0]       wb_wr_q, wb_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic luse, mdhaz, stall_c, bubble_c;
  fwd_e fwd_a_c, fwd_b_c;

  // MEM is checked first so the youngest producer wins; loads in MEM never forward.
  function automatic fwd_e fwd_sel(
    input logic       ex_v,
    input logic [5:0] r,
    input logic       m_v,
    input logic [5:0] m_wr,
    input logic       m_ld,
    input logic       w_v,
    input logic [5:0] w_wr
  );
    fwd_e sel;
    sel = FWD_RF;
    if (ex_v && r != '0 && r != HILO_ID) begin
      if (m_v && m_wr == r && !m_ld)
        sel = FWD_MEM;
      else if (w_v && w_wr == r)
        sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    luse = id_valid && ex_q.v && ex_q.ld && ex_q.wr != '0 && ex_q.wr != HILO_ID &&
           (id_rr1 == ex_q.wr || id_rr2 == ex_q.wr);
    mdhaz = id_valid && cnt_q != '0 &&
            (id_rr1 == HILO_ID || id_rr2 == HILO_ID || id_md_start);
    stall_c  = (luse || mdhaz) && !ex_branch_taken;
    bubble_c = stall_c || ex_branch_taken;
    fwd_a_c  = fwd_sel(ex_q.v, ex_q.rr1, mem_v_q, mem_wr_q, mem_ld_q, wb_v_q, wb_wr_q);
    fwd_b_c  = fwd_sel(ex_q.v, ex_q.rr2, mem_v_q, mem_wr_q, mem_ld_q, wb_v_q, wb_wr_q);
  end

  always_comb begin
    wb_v_d   = mem_v_q;
    wb_wr_d  = mem_wr_q;
    mem_v_d  = ex_q.v;
    mem_wr_d = ex_q.wr;
    mem_ld_d = ex_q.ld;
    ex_d     = '0;
    if (!bubble_c)
      ex_d = {id_valid, id_rr1, id_rr2, id_wr, id_is_load};

    // Only a mul/div that really enters EX claims HI/LO.
    cnt_d = cnt_q;
    if (id_valid && id_md_start && !bubble_c)
      cnt_d = id_md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q     <= '0;
      mem_v_q  <= 1'b0;
      mem_wr_q <= '0;
      mem_ld_q <= 1'b0;
      wb_v_q   <= 1'b0;
      wb_wr_q  <= '0;
      cnt_q    <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_v_q  <= mem_v_d;
      mem_wr_q <= mem_wr_d;
      mem_ld_q <= mem_ld_d;
      wb_v_q   <= wb_v_d;
      wb_wr_q  <= wb_wr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stall     = stall_c;
  assign bubble_ex = bubble_c;
  assign flush_id  = ex_branch_taken;
  assign fwd_a     = fwd_a_c;
  assign fwd_b     = fwd_b_c;
  assign md_busy   = (cnt_q != '0);

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed scenarios plus randomized traffic checked
// against an instruction-history model of the pipeline.
module tb_hazard_scheduler;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_rr1, id_rr2, id_wr;
  logic       id_is_load, id_md_start, id_md_is_div, ex_branch_taken;
  logic       stall, bubble_ex, flush_id, md_busy;
  logic [1:0] fwd_a, fwd_b;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rr1(id_rr1), .id_rr2(id_rr2),
    .id_wr(id_wr), .id_is_load(id_is_load), .id_md_start(id_md_start),
    .id_md_is_div(id_md_is_div), .ex_branch_taken(ex_branch_taken), .stall(stall),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Model: history of what entered EX (0 = EX, 1 = MEM, 2 = WB) and the
  // edge count at which HI/LO becomes free again.
  typedef struct {bit v; int rr1; int rr2; int wr; bit ld;} ins_t;
  ins_t pipe[3];
  int   cyc = 0;
  int   busy_until = 0;
  bit   exp_stall, exp_bubble, exp_flush, exp_busy;
  logic [1:0] exp_fa, exp_fb;

  function automatic int src_stage(int r);
    if (!pipe[0].v || r == 0 || r == 33) return 0;
    for (int i = 1; i <= 2; i++)
      if (pipe[i].v && pipe[i].wr == r && !(i == 1 && pipe[i].ld)) return i;
    return 0;
  endfunction

  function automatic void model_eval();
    bit luse, mdhaz;
    luse = id_valid && pipe[0].v && pipe[0].ld && pipe[0].wr != 0 && pipe[0].wr != 33 &&
           (int'(id_rr1) == pipe[0].wr || int'(id_rr2) == pipe[0].wr);
    exp_busy   = cyc < busy_until;
    mdhaz      = id_valid && exp_busy && (id_rr1 == 33 || id_rr2 == 33 || id_md_start);
    exp_flush  = ex_branch_taken;
    exp_stall  = (luse || mdhaz) && !ex_branch_taken;
    exp_bubble = exp_stall || ex_branch_taken;
    exp_fa     = 2'(src_stage(int'(pipe[0].rr1)));
    exp_fb     = 2'(src_stage(int'(pipe[0].rr2)));
  endfunction

  task automatic tick();
    bit enter;
    model_eval();
    enter = id_valid && !exp_bubble;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0, 0};
      busy_until = 0;
    end else begin
      if (enter && id_md_start) busy_until = cyc + (id_md_is_div ? DIV_LAT : MUL_LAT);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{enter, int'(id_rr1), int'(id_rr2), int'(id_wr), id_is_load};
    end
    #1;
  endtask

  task automatic set_id(bit v, int r1, int r2, int w, bit ld, bit md, bit dv);
    id_valid = v; id_rr1 = 6'(r1); id_rr2 = 6'(r2); id_wr = 6'(w);
    id_is_load = ld; id_md_start = md; id_md_is_div = dv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
    n_cmp++; if (bubble_ex !== 1'b0) begin n_bad++; $display("FAIL reset_bubble got %b want 0", bubble_ex); end
    n_cmp++; if (flush_id !== 1'b0) begin n_bad++; $display("FAIL reset_flush got %b want 0", flush_id); end
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_bad++; $display("FAIL reset_fwd got %b%b want 0000", fwd_a, fwd_b); end
    n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", md_busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    set_id(1, 0, 0, 8, 1, 0, 0); tick();
    set_id(1, 8, 9, 10, 0, 0, 0); #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %b want 1", stall); end
    n_cmp++; if (bubble_ex !== 1'b1) begin n_bad++; $display("FAIL lu_bubble got %b want 1", bubble_ex); end
    tick(); #1;
    n_cmp++; if ({stall, bubble_ex} !== 2'b00) begin n_bad++; $display("FAIL lu_one_cycle got %b want 00", {stall, bubble_ex}); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); #1;
    n_cmp++; if (fwd_a !== 2'b10) begin n_bad++; $display("FAIL lu_fwd_a got %b want 10", fwd_a); end
    n_cmp++; if (fwd_b !== 2'b00) begin n_bad++; $display("FAIL lu_fwd_b got %b want 00", fwd_b); end
    tick();
  endtask

  task automatic test_forwarding();
    set_id(1, 0, 0, 5, 0, 0, 0); tick();
    set_id(1, 0, 0, 5, 0, 0, 0); tick();
    set_id(1, 5, 5, 6, 0, 0, 0); tick();
    set_id(0, 0, 0, 0, 0, 0, 0); #1;
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b0101) begin n_bad++; $display("FAIL fwd_mem_prio got %b%b want 0101", fwd_a, fwd_b); end
    set_id(1, 0, 0, 5, 0, 0, 0); tick();
    set_id(1, 0, 0, 0, 0, 0, 0); tick();
    set_id(1, 5, 5, 6, 0, 0, 0); tick();
    set_id(0, 0, 0, 0, 0, 0, 0); #1;
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b1010) begin n_bad++; $display("FAIL fwd_wb got %b%b want 1010", fwd_a, fwd_b); end
    tick();
  endtask

  task automatic test_reg0();
    set_id(1, 0, 0, 0, 1, 0, 0); tick();
    set_id(1, 0, 0, 7, 0, 0, 0); #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reg0_stall got %b want 0", stall); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); #1;
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_bad++; $display("FAIL reg0_fwd got %b%b want 0000", fwd_a, fwd_b); end
    tick();
  endtask

  task automatic test_muldiv();
    int busy_cycles = 0;
    set_id(1, 0, 0, 0, 0, 1, 1); tick();
    set_id(1, 0, 0, 0, 0, 1, 0); #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL md_multu_stall got %b want 1", stall); end
    set_id(1, 33, 0, 9, 0, 0, 0); #1;
    for (int i = 0; i < 40 && md_busy === 1'b1; i++) begin
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL md_mflo_stall got %b want 1 at busy cycle %0d", stall, i); end
      busy_cycles++;
      tick(); #1;
    end
    n_cmp++; if (busy_cycles != DIV_LAT) begin n_bad++; $display("FAIL md_busy_len got %0d want %0d", busy_cycles, DIV_LAT); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL md_release got %b want 0", stall); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); #1;
    n_cmp++; if (fwd_a !== 2'b00) begin n_bad++; $display("FAIL md_mflo_fwd got %b want 00", fwd_a); end
    tick();
  endtask

  task automatic test_branch_priority();
    set_id(1, 0, 0, 8, 1, 0, 0); tick();
    set_id(1, 8, 0, 0, 0, 1, 0); ex_branch_taken = 1'b1; #1;
    n_cmp++; if ({stall, flush_id, bubble_ex} !== 3'b011) begin n_bad++; $display("FAIL br_prio got %b want 011", {stall, flush_id, bubble_ex}); end
    tick();
    ex_branch_taken = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0); #1;
    n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL br_no_md got %b want 0", md_busy); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_id(1, 0, 0, 0, 0, 1, 1); tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (6) tick();
    set_id(1, 0, 0, 8, 1, 0, 0); tick();
    set_id(1, 8, 0, 10, 0, 0, 0); #1;
    n_cmp++; if ({stall, md_busy} !== 2'b11) begin n_bad++; $display("FAIL rm_pre got %b want 11", {stall, md_busy}); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    n_cmp++; if ({stall, bubble_ex, md_busy} !== 3'b000) begin n_bad++; $display("FAIL rm_clear got %b want 000", {stall, bubble_ex, md_busy}); end
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_bad++; $display("FAIL rm_fwd got %b%b want 0000", fwd_a, fwd_b); end
    tick();
  endtask

  task automatic test_random();
    int regs[5] = '{0, 1, 2, 3, 33};
    logic [7:0] got, want;
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 7) != 0, regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
             regs[$urandom_range(0, 4)], $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 1) == 1);
      #1;
      model_eval();
      got  = {stall, bubble_ex, flush_id, fwd_a, fwd_b, md_busy};
      want = {exp_stall, exp_bubble, exp_flush, exp_fa, exp_fb, exp_busy};
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL rand_%0d {stall,bub,flush,fa,fb,busy} got %b want %b", n, got, want); end
      tick();
    end
    rst_n = 1'b1; ex_branch_taken = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_reg0();
    test_muldiv();
    test_branch_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
